// File: rtl/sprite_pkg.sv
// Shared constants for the sprite blitter: screen size, transparent key, address fields, FSM states.
// Pure declarations: no latency, no backpressure.
package sprite_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam logic [8:0] TRANSPARENT = 9'h1FF;

    localparam int FRAME_W = 4;
    localparam int ROW_W   = 6;
    localparam int COL_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sprite_scan_counter.sv
// Raster row/col counter with wrap; last is combinational on the current count.
// No backpressure: advances on every cycle that advance is high.
module sprite_scan_counter
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [COL_W-1:0] width,
    input  logic [ROW_W-1:0] height,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);
    logic [COL_W-1:0] col_max;
    logic [ROW_W-1:0] row_max;
    logic             col_end;

    assign col_max = width - COL_W'(1);
    assign row_max = height - ROW_W'(1);
    assign col_end = (col == col_max);
    assign last    = col_end && (row == row_max);

    // Returning to 0,0 after the last texel leaves the counter ready for the next scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear || (advance && last)) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end
endmodule

// File: rtl/sprite_blitter.sv
// Scans one sprite frame from sprite memory and emits a clipped, colour-keyed pixel-plot stream.
// Latency: texel addressed in cycle c plots in cycle c+2; no backpressure, one texel per cycle.
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [2:0]  SpriteSel,
    input  logic [3:0]  Frame,
    input  logic [7:0]  PosX,
    input  logic [6:0]  PosY,
    output logic        Busy,
    output logic        Done,
    output logic [2:0]  MemSel,
    output logic [15:0] MemAddr,
    input  logic [8:0]  MemData,
    input  logic [5:0]  SprWidth,
    input  logic [5:0]  SprHeight,
    input  logic [2:0]  SprAnimSteps,
    output logic [7:0]  VgaX,
    output logic [6:0]  VgaY,
    output logic [8:0]  VgaColour,
    output logic        VgaPlot
);
    state_t             state;
    logic [FRAME_W-1:0] frame_req;
    logic [FRAME_W-1:0] frame_q;
    logic [7:0]         pos_x;
    logic [6:0]         pos_y;
    logic [COL_W-1:0]   w_q;
    logic [ROW_W-1:0]   h_q;
    logic               drain_cnt;

    logic [ROW_W-1:0]   cnt_row;
    logic [COL_W-1:0]   cnt_col;
    logic               cnt_last;

    logic [2:0]         steps_eff;
    logic [FRAME_W-1:0] frame_eff;

    logic               s1_vld;
    logic [8:0]         s1_x;
    logic [8:0]         s1_y;
    logic               plot_ok;

    // A sprite with zero animation steps still has one frame; out-of-range frames fall back to 0.
    assign steps_eff = (SprAnimSteps == 3'd0) ? 3'd1 : SprAnimSteps;
    assign frame_eff = (frame_req < {1'b0, steps_eff}) ? frame_req : '0;

    assign MemAddr = {frame_q, cnt_row, cnt_col};

    sprite_scan_counter u_scan (
        .clk     (Clock),
        .rst_n   (Resetn),
        .clear   (state == ST_LOAD),
        .advance (state == ST_SCAN),
        .width   (w_q),
        .height  (h_q),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            MemSel    <= '0;
            frame_req <= '0;
            frame_q   <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        MemSel    <= SpriteSel;
                        frame_req <= Frame;
                        pos_x     <= PosX;
                        pos_y     <= PosY;
                        Busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_q     <= SprWidth;
                    h_q     <= SprHeight;
                    frame_q <= frame_eff;
                    if (SprWidth == '0 || SprHeight == '0) begin
                        Done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cnt_last) begin
                        drain_cnt <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        Done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sums are 9 bits so a sprite hanging off the right/bottom edge clips instead of wrapping.
    assign plot_ok = s1_vld
                  && (s1_x < 9'(SCREEN_W))
                  && (s1_y < 9'(SCREEN_H))
                  && (MemData != TRANSPARENT);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            s1_vld    <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            VgaPlot   <= 1'b0;
            VgaX      <= '0;
            VgaY      <= '0;
            VgaColour <= '0;
        end else begin
            s1_vld  <= (state == ST_SCAN);
            s1_x    <= {1'b0, pos_x} + {3'b000, cnt_col};
            s1_y    <= {2'b00, pos_y} + {3'b000, cnt_row};
            VgaPlot <= plot_ok;
            if (plot_ok) begin
                VgaX      <= s1_x[7:0];
                VgaY      <= s1_y[6:0];
                VgaColour <= MemData;
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed, table-driven bench for sprite_blitter with a one-cycle-latency sprite memory model.
module tb_sprite_blitter;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic [2:0]  SpriteSel;
    logic [3:0]  Frame;
    logic [7:0]  PosX;
    logic [6:0]  PosY;
    logic        Busy;
    logic        Done;
    logic [2:0]  MemSel;
    logic [15:0] MemAddr;
    logic [8:0]  MemData = 9'h000;
    logic [5:0]  SprWidth;
    logic [5:0]  SprHeight;
    logic [2:0]  SprAnimSteps;
    logic [7:0]  VgaX;
    logic [6:0]  VgaY;
    logic [8:0]  VgaColour;
    logic        VgaPlot;

    sprite_blitter dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .SpriteSel(SpriteSel),
        .Frame(Frame), .PosX(PosX), .PosY(PosY), .Busy(Busy), .Done(Done),
        .MemSel(MemSel), .MemAddr(MemAddr), .MemData(MemData),
        .SprWidth(SprWidth), .SprHeight(SprHeight), .SprAnimSteps(SprAnimSteps),
        .VgaX(VgaX), .VgaY(VgaY), .VgaColour(VgaColour), .VgaPlot(VgaPlot)
    );

    always #5 Clock = ~Clock;

    // mode 0: every texel opaque 0x0AA; mode 1: odd columns transparent, even columns 0x100|addr[5:0]
    int mode = 0;
    function automatic logic [8:0] texel(input int m, input logic [15:0] a);
        if (m == 0) return 9'h0AA;
        if (a[0]) return 9'h1FF;
        return {3'b100, a[5:0]};
    endfunction

    always @(posedge Clock) MemData <= texel(mode, MemAddr);

    typedef struct {
        int sel, w, h, steps, frame, px, py, m;
        int exp_done, exp_plots, exp_field;
    } vec_t;

    typedef struct {
        int cyc, x, y, col;
    } plot_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Starts a draw at a negedge (that cycle is cycle 0) and checks it against a raster model.
    task automatic do_draw(input string name, input vec_t v);
        plot_t got[$];
        plot_t exp[$];
        int done_cyc = -1;
        int addr_err = 0;
        int sel_err  = 0;
        int plot_err = 0;
        int field    = -1;
        int steps, eff, k, busy_after, n;
        logic [15:0] a;
        steps = (v.steps == 0) ? 1 : v.steps;
        eff   = (v.frame < steps) ? v.frame : 0;
        for (int r = 0; r < v.h; r++) begin
            for (int c = 0; c < v.w; c++) begin
                a = 16'(eff * 4096 + r * 64 + c);
                if (v.px + c < 160 && v.py + r < 120 && texel(v.m, a) != 9'h1FF)
                    exp.push_back('{4 + r * v.w + c, v.px + c, v.py + r, int'(texel(v.m, a))});
            end
        end
        mode         = v.m;
        SpriteSel    = 3'(v.sel);
        Frame        = 4'(v.frame);
        PosX         = 8'(v.px);
        PosY         = 7'(v.py);
        SprWidth     = 6'(v.w);
        SprHeight    = 6'(v.h);
        SprAnimSteps = 3'(v.steps);
        Start        = 1'b1;
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(negedge Clock);
            if (cyc == 1) Start = 1'b0;
            if (VgaPlot) got.push_back('{cyc, int'(VgaX), int'(VgaY), int'(VgaColour)});
            if (MemSel != 3'(v.sel)) sel_err++;
            if (v.w * v.h == 0) begin
                if (MemAddr != 16'h0000) addr_err++;
            end else if (cyc >= 2 && cyc <= v.w * v.h + 1) begin
                k = cyc - 2;
                if (MemAddr != 16'(eff * 4096 + (k / v.w) * 64 + (k % v.w))) addr_err++;
                if (cyc == 2) field = int'(MemAddr[15:12]);
            end
            if (Done) done_cyc = cyc;
        end
        @(negedge Clock);
        busy_after = int'(Busy);
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++)
            if (got[i] != exp[i]) plot_err++;
        chk({name, " done_cycle"}, done_cyc, v.exp_done);
        chk({name, " plot_count"}, got.size(), v.exp_plots);
        chk({name, " model_count"}, got.size(), exp.size());
        chk({name, " plot_content_errs"}, plot_err, 0);
        chk({name, " memaddr_errs"}, addr_err, 0);
        chk({name, " memsel_errs"}, sel_err, 0);
        if (v.w * v.h != 0) chk({name, " frame_field"}, field, v.exp_field);
        chk({name, " busy_after_done"}, busy_after, 0);
    endtask

    vec_t vecs[9];
    vec_t rv;
    int dones, busy_low, d1, d2;

    initial begin
        //          sel w  h  st fr  px   py  m  done plots field
        vecs[0] = '{1, 2, 3, 1, 0, 10,  20,  0, 10,  6,  0};
        vecs[1] = '{2, 1, 1, 3, 2, 0,   0,   1, 5,   1,  2};
        vecs[2] = '{2, 1, 1, 3, 5, 0,   0,   1, 5,   1,  0};
        vecs[3] = '{3, 4, 4, 1, 0, 158, 118, 1, 20,  2,  0};
        vecs[4] = '{4, 0, 3, 1, 0, 5,   5,   0, 2,   0,  0};
        vecs[5] = '{5, 1, 1, 0, 1, 3,   4,   0, 5,   1,  0};
        vecs[6] = '{6, 3, 0, 1, 0, 5,   5,   0, 2,   0,  0};
        vecs[7] = '{7, 2, 1, 1, 0, 255, 0,   0, 6,   0,  0};
        vecs[8] = '{0, 3, 2, 2, 1, 157, 119, 1, 10,  2,  1};

        Resetn = 1'b0; Start = 1'b0; SpriteSel = '0; Frame = '0; PosX = '0; PosY = '0;
        SprWidth = '0; SprHeight = '0; SprAnimSteps = '0;
        repeat (3) @(negedge Clock);
        chk("reset Busy", int'(Busy), 0);
        chk("reset Done", int'(Done), 0);
        chk("reset VgaPlot", int'(VgaPlot), 0);
        chk("reset MemSel", int'(MemSel), 0);
        chk("reset MemAddr", int'(MemAddr), 0);
        chk("reset VgaXYC", int'(VgaX) + int'(VgaY) + int'(VgaColour), 0);
        Resetn = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 9; i++) do_draw($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a 4x4 scan aborts without Done.
        mode = 0; SpriteSel = 3'd2; Frame = 4'd0; PosX = 8'd0; PosY = 7'd0;
        SprWidth = 6'd4; SprHeight = 6'd4; SprAnimSteps = 3'd1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        chk("midreset Busy", int'(Busy), 0);
        chk("midreset VgaPlot", int'(VgaPlot), 0);
        chk("midreset MemSel", int'(MemSel), 0);
        Resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge Clock);
            if (Done) dones++;
        end
        chk("midreset no_done", dones, 0);
        rv = '{2, 4, 4, 1, 0, 0, 0, 0, 20, 16, 0};
        do_draw("after_reset", rv);

        // Start held high: the Done-cycle Start is ignored, one idle cycle between draws.
        mode = 0; SprWidth = 6'd1; SprHeight = 6'd1; SprAnimSteps = 3'd1;
        PosX = 8'd50; PosY = 7'd60; SpriteSel = 3'd1; Frame = 4'd0;
        Start = 1'b1;
        busy_low = 0; d1 = -1; d2 = -1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge Clock);
            if (!Busy) busy_low++;
            if (Done && d1 < 0) d1 = cyc;
            else if (Done) d2 = cyc;
        end
        Start = 1'b0;
        chk("b2b first_done", d1, 5);
        chk("b2b second_done", d2, 11);
        chk("b2b idle_cycles", busy_low, 1);
        repeat (2) @(negedge Clock);
        chk("b2b idle_after", int'(Busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
